// File: rtl/stage_execute_rle_if.sv
// ----------------------------------------------------------------------------
// stage_execute_rle_if
// Bundles the operation handshake, data-pointer, data-RAM read, I/O channel
// and result bus of the RLE execute stage.
//   operation_in/count_in/op_valid/op_ack : upstream operation handshake
//   dp/dp_ce/dp_down/dp_step/dp_cache     : data-pointer update and cache
//   dce/da/dd                             : data RAM read (dd one cycle late)
//   cd/crda/cack                          : input channel byte/ready/consume
//   od/owr/ordy                           : output channel byte/strobe/ready
//   operation/count/a                     : registered result to next stage
// The slave modport is the execute stage; master is its environment.
// ----------------------------------------------------------------------------
interface stage_execute_rle_if #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 4
);
    localparam int OPCODE_MSB = 7;

    logic [OPCODE_MSB:0] operation_in;
    logic [C_WIDTH-1:0]  count_in;
    logic                op_valid;
    logic                op_ack;
    logic [A_WIDTH-1:0]  dp;
    logic                dp_ce;
    logic                dp_down;
    logic [C_WIDTH:0]    dp_step;
    logic [A_WIDTH-1:0]  dp_cache;
    logic                dce;
    logic [A_WIDTH-1:0]  da;
    logic [D_WIDTH-1:0]  dd;
    logic [7:0]          cd;
    logic                crda;
    logic                cack;
    logic [D_WIDTH-1:0]  od;
    logic                owr;
    logic                ordy;
    logic [OPCODE_MSB:0] operation;
    logic [C_WIDTH-1:0]  count;
    logic [D_WIDTH-1:0]  a;

    modport master (
        output operation_in, count_in, op_valid, dp, dd, cd, crda, ordy,
        input  op_ack, dp_ce, dp_down, dp_step, dp_cache, dce, da, cack,
               od, owr, operation, count, a
    );

    modport slave (
        input  operation_in, count_in, op_valid, dp, dd, cd, crda, ordy,
        output op_ack, dp_ce, dp_down, dp_step, dp_cache, dce, da, cack,
               od, owr, operation, count, a
    );
endinterface

// File: rtl/stage_execute_rle.sv
// ----------------------------------------------------------------------------
// stage_execute_rle
// Execute stage of a run-length-encoded brainfuck-style processor. Each
// accepted operation carries a repeat count; the stage reads the current cell
// (or forwards the value the previous operation just produced), performs the
// arithmetic or I/O, and hands a registered result to the write-back stage.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : stage_execute_rle_if slave (handshake, pointer, RAM, I/O,
//                result) -- see the interface file for the signal list
// ----------------------------------------------------------------------------
module stage_execute_rle #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8,
    parameter int C_WIDTH = 4
) (
    input logic                clk,
    input logic                reset,
    stage_execute_rle_if.slave bus
);
    localparam int OPCODE_MSB   = 7;
    localparam int OP_INC       = 0;
    localparam int OP_DEC       = 1;
    localparam int OP_INCDP     = 2;
    localparam int OP_DECDP     = 3;
    localparam int OP_IN        = 4;
    localparam int OP_OUT       = 5;
    localparam int OP_LOOPBEGIN = 6;
    localparam int OP_LOOPEND   = 7;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT} state_t;

    state_t              r_state;
    logic [OPCODE_MSB:0] r_operation;
    logic [C_WIDTH-1:0]  r_count;
    logic [D_WIDTH-1:0]  r_a;
    logic [D_WIDTH-1:0]  r_hold;
    logic [A_WIDTH-1:0]  r_dpCache;
    logic                r_ddValid;

    state_t              w_nextState;
    logic                w_isInc, w_isDec, w_isIncDp, w_isDecDp;
    logic                w_isIn, w_isOut, w_isLoopBegin, w_isLoopEnd;
    logic [C_WIDTH:0]    w_step;
    logic [D_WIDTH-1:0]  w_stepD;
    logic                w_needMem, w_dirty;
    logic                w_ack, w_stall, w_dce, w_cack, w_owr, w_latchHold;
    logic [D_WIDTH-1:0]  w_datum, w_od, w_result;

    assign w_isInc       = bus.operation_in[OP_INC];
    assign w_isDec       = bus.operation_in[OP_DEC];
    assign w_isIncDp     = bus.operation_in[OP_INCDP];
    assign w_isDecDp     = bus.operation_in[OP_DECDP];
    assign w_isIn        = bus.operation_in[OP_IN];
    assign w_isOut       = bus.operation_in[OP_OUT];
    assign w_isLoopBegin = bus.operation_in[OP_LOOPBEGIN];
    assign w_isLoopEnd   = bus.operation_in[OP_LOOPEND];

    // A zero count encodes a full 2^C_WIDTH run, so the MSB of the step is
    // simply "count is zero" on top of the (then all-zero) count bits.
    assign w_step  = {(bus.count_in == '0), bus.count_in};
    assign w_stepD = D_WIDTH'(w_step);

    assign w_needMem = w_isInc | w_isDec | w_isOut | w_isLoopBegin | w_isLoopEnd;

    // The previous result is still in flight to the RAM when it modified the
    // cell, so its value must be forwarded instead of read back.
    assign w_dirty = r_operation[OP_INC] | r_operation[OP_DEC] | r_operation[OP_IN];

    // Per-cycle control: decides acceptance, RAM issue, I/O strobes and the
    // next FSM state. Everything is held low while reset is asserted, and a
    // missing op_valid abandons any fetch or emit in progress.
    always_comb begin
        w_nextState = S_IDLE;
        w_ack       = 1'b0;
        w_stall     = 1'b0;
        w_dce       = 1'b0;
        w_cack      = 1'b0;
        w_owr       = 1'b0;
        w_latchHold = 1'b0;
        w_datum     = '0;
        w_od        = '0;
        if (!reset && bus.op_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_isIn) begin
                        if (bus.crda) begin
                            w_cack = 1'b1;
                            w_ack  = 1'b1;
                        end else begin
                            w_stall = 1'b1;
                        end
                    end else if (w_needMem && w_dirty) begin
                        w_datum = r_a;
                        if (w_isOut) begin
                            w_owr = 1'b1;
                            w_od  = r_a;
                            if (bus.ordy) begin
                                w_ack = 1'b1;
                            end else begin
                                w_stall     = 1'b1;
                                w_latchHold = 1'b1;
                                w_nextState = S_EMIT;
                            end
                        end else begin
                            w_ack = 1'b1;
                        end
                    end else if (w_needMem) begin
                        w_dce       = 1'b1;
                        w_stall     = 1'b1;
                        w_nextState = S_FETCH;
                    end else begin
                        w_ack = 1'b1;
                    end
                end
                S_FETCH: begin
                    w_dce = 1'b1;
                    if (r_ddValid) begin
                        w_datum = bus.dd;
                        if (w_isOut) begin
                            w_owr = 1'b1;
                            w_od  = bus.dd;
                            if (bus.ordy) begin
                                w_ack = 1'b1;
                            end else begin
                                w_stall     = 1'b1;
                                w_latchHold = 1'b1;
                                w_nextState = S_EMIT;
                            end
                        end else begin
                            w_ack = 1'b1;
                        end
                    end else begin
                        // No read was issued last cycle; reissue and wait.
                        w_stall     = 1'b1;
                        w_nextState = S_FETCH;
                    end
                end
                S_EMIT: begin
                    w_owr   = 1'b1;
                    w_od    = r_hold;
                    w_datum = r_hold;
                    if (bus.ordy) begin
                        w_ack = 1'b1;
                    end else begin
                        w_stall     = 1'b1;
                        w_nextState = S_EMIT;
                    end
                end
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Result value registered on completion; all arithmetic wraps at D_WIDTH.
    always_comb begin
        w_result = '0;
        if (w_isInc) begin
            w_result = w_datum + w_stepD;
        end else if (w_isDec) begin
            w_result = w_datum - w_stepD;
        end else if (w_isIn) begin
            w_result = D_WIDTH'(bus.cd);
        end else if (w_isOut | w_isLoopBegin | w_isLoopEnd) begin
            w_result = w_datum;
        end
    end

    // State and result registers. Stalls push a bubble downstream so a
    // half-finished operation is never mistaken for a completed one; idle
    // cycles leave the result untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_operation <= '0;
            r_count     <= '0;
            r_a         <= '0;
            r_hold      <= '0;
            r_dpCache   <= '0;
            r_ddValid   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_dpCache <= bus.dp;
            r_ddValid <= w_dce;
            if (w_latchHold) begin
                r_hold <= w_datum;
            end
            if (w_ack) begin
                r_operation <= bus.operation_in;
                r_count     <= bus.count_in;
                r_a         <= w_result;
            end else if (w_stall) begin
                r_operation <= '0;
                r_count     <= '0;
                r_a         <= '0;
            end
        end
    end

    assign bus.op_ack    = w_ack;
    assign bus.dp_ce     = w_ack & (w_isIncDp | w_isDecDp);
    assign bus.dp_down   = w_ack & w_isDecDp;
    assign bus.dp_step   = w_step;
    assign bus.dp_cache  = r_dpCache;
    assign bus.dce       = w_dce;
    assign bus.da        = bus.dp;
    assign bus.cack      = w_cack;
    assign bus.od        = w_od;
    assign bus.owr       = w_owr;
    assign bus.operation = r_operation;
    assign bus.count     = r_count;
    assign bus.a         = r_a;
endmodule

// File: tb/tb_stage_execute_rle.sv
// ----------------------------------------------------------------------------
// tb_stage_execute_rle
// Drives stage_execute_rle with directed and random operations. An environment
// block models the data RAM, write-back and pointer register; a transaction
// model tracks cells, pointer and the expected registered results.
// ----------------------------------------------------------------------------
module tb_stage_execute_rle;
    localparam int A_WIDTH   = 12;
    localparam int D_WIDTH   = 8;
    localparam int C_WIDTH   = 4;
    localparam int RAM_DEPTH = 1 << A_WIDTH;

    localparam logic [7:0] OP_INC   = 8'h01;
    localparam logic [7:0] OP_DEC   = 8'h02;
    localparam logic [7:0] OP_INCDP = 8'h04;
    localparam logic [7:0] OP_DECDP = 8'h08;
    localparam logic [7:0] OP_IN    = 8'h10;
    localparam logic [7:0] OP_OUT   = 8'h20;
    localparam logic [7:0] OP_LB    = 8'h40;
    localparam logic [7:0] OP_LE    = 8'h80;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stage_execute_rle_if #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .C_WIDTH(C_WIDTH)) ifc ();

    stage_execute_rle #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .C_WIDTH(C_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    logic [7:0]         initVal  [RAM_DEPTH];
    logic [7:0]         envRam   [RAM_DEPTH];
    logic [7:0]         modelMem [RAM_DEPTH];
    logic [A_WIDTH-1:0] dpReg;
    logic [D_WIDTH-1:0] ddReg;

    logic [A_WIDTH-1:0] modelDp;
    bit                 modelDirty;
    logic [7:0]         modelOp;
    logic [3:0]         modelCnt;
    logic [7:0]         modelA;

    int checks   = 0;
    int failures = 0;

    assign ifc.dp = dpReg;
    assign ifc.dd = ddReg;

    // Environment: RAM with one-cycle read latency, write-back of results to
    // the cached pointer address, and the data-pointer register.
    always @(posedge clk) begin
        if (reset) begin
            dpReg <= '0;
            ddReg <= '0;
            for (int i = 0; i < RAM_DEPTH; i++) envRam[i] <= initVal[i];
        end else begin
            if (ifc.dce) ddReg <= envRam[ifc.da];
            if (ifc.operation == OP_INC || ifc.operation == OP_DEC || ifc.operation == OP_IN)
                envRam[ifc.dp_cache] <= ifc.a;
            if (ifc.dp_ce)
                dpReg <= ifc.dp_down ? dpReg - A_WIDTH'(ifc.dp_step) : dpReg + A_WIDTH'(ifc.dp_step);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One operation, held until acknowledged; checks every cycle against the
    // transaction model and updates the model on completion.
    task automatic applyStimulus(input logic [7:0] op, input logic [3:0] cnt, input logic [7:0] cdVal,
                                 input int crdaDelay, input int ordyDelay,
                                 output int cycles, output int dceCycles, output int owrCycles);
        logic [7:0]         step8;
        logic [A_WIDTH-1:0] dpBefore;
        logic [7:0]         expA;
        logic [7:0]         expOd;
        bit                 isIn, isOut, needMem, fetch, acked;
        int                 expCycles;
        step8     = (cnt == 4'd0) ? 8'd16 : {4'd0, cnt};
        dpBefore  = modelDp;
        isIn      = (op == OP_IN);
        isOut     = (op == OP_OUT);
        needMem   = (op == OP_INC) || (op == OP_DEC) || isOut || (op == OP_LB) || (op == OP_LE);
        fetch     = needMem && !modelDirty;
        expOd     = modelMem[modelDp];
        expCycles = 1 + (fetch ? 1 : 0) + (isIn ? crdaDelay : 0) + (isOut ? ordyDelay : 0);
        case (op)
            OP_INC:              expA = modelMem[modelDp] + step8;
            OP_DEC:              expA = modelMem[modelDp] - step8;
            OP_IN:               expA = cdVal;
            OP_OUT, OP_LB, OP_LE: expA = modelMem[modelDp];
            default:             expA = 8'd0;
        endcase
        cycles = 0; dceCycles = 0; owrCycles = 0; acked = 0;
        @(negedge clk);
        ifc.operation_in = op;
        ifc.count_in     = cnt;
        ifc.cd           = cdVal;
        ifc.op_valid     = 1'b1;
        while (!acked && cycles < 40) begin
            ifc.crda = (cycles >= crdaDelay);
            ifc.ordy = (owrCycles >= ordyDelay);
            #1;
            checkOutput("owr_cack_exclusive", {31'd0, ifc.owr & ifc.cack}, 32'd0);
            checkOutput("cack", {31'd0, ifc.cack}, {31'd0, isIn && ifc.crda});
            if (ifc.owr) begin
                checkOutput("od", {24'd0, ifc.od}, {24'd0, expOd});
                owrCycles++;
            end
            if (ifc.dce) begin
                checkOutput("da", {20'd0, ifc.da}, {20'd0, modelDp});
                dceCycles++;
            end
            if (ifc.op_ack) begin
                acked = 1;
                checkOutput("dp_ce", {31'd0, ifc.dp_ce}, {31'd0, (op == OP_INCDP) || (op == OP_DECDP)});
                checkOutput("dp_down", {31'd0, ifc.dp_down}, {31'd0, op == OP_DECDP});
                checkOutput("dp_step", {27'd0, ifc.dp_step}, {24'd0, step8});
            end else begin
                checkOutput("dp_ce_stall", {31'd0, ifc.dp_ce}, 32'd0);
            end
            @(posedge clk);
            #1;
            cycles++;
            if (!acked) begin
                checkOutput("bubble_operation", {24'd0, ifc.operation}, 32'd0);
                checkOutput("bubble_count", {28'd0, ifc.count}, 32'd0);
                checkOutput("bubble_a", {24'd0, ifc.a}, 32'd0);
                @(negedge clk);
            end
        end
        checkOutput("ack_seen", {31'd0, acked}, 32'd1);
        checkOutput("latency", cycles, expCycles);
        checkOutput("dce_cycles", dceCycles, fetch ? 2 : 0);
        checkOutput("owr_cycles", owrCycles, isOut ? ordyDelay + 1 : 0);
        if (acked) begin
            checkOutput("operation", {24'd0, ifc.operation}, {24'd0, op});
            checkOutput("count", {28'd0, ifc.count}, {28'd0, cnt});
            checkOutput("a", {24'd0, ifc.a}, {24'd0, expA});
            checkOutput("dp_cache", {20'd0, ifc.dp_cache}, {20'd0, dpBefore});
            modelOp    = op;
            modelCnt   = cnt;
            modelA     = expA;
            modelDirty = (op == OP_INC) || (op == OP_DEC) || (op == OP_IN);
            if (modelDirty) modelMem[dpBefore] = expA;
            if (op == OP_INCDP) modelDp = modelDp + A_WIDTH'(step8);
            if (op == OP_DECDP) modelDp = modelDp - A_WIDTH'(step8);
            checkOutput("dp", {20'd0, ifc.dp}, {20'd0, modelDp});
        end
    endtask

    // Cycles with no operation offered: no strobes, result registers hold.
    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            ifc.op_valid = 1'b0;
            ifc.crda     = 1'($urandom);
            ifc.ordy     = 1'($urandom);
            #1;
            checkOutput("idle_strobes", {28'd0, ifc.op_ack, ifc.owr, ifc.cack, ifc.dce}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput("idle_operation", {24'd0, ifc.operation}, {24'd0, modelOp});
            checkOutput("idle_count", {28'd0, ifc.count}, {28'd0, modelCnt});
            checkOutput("idle_a", {24'd0, ifc.a}, {24'd0, modelA});
        end
    endtask

    // Directed scenarios first, then a randomized run, then reset mid-emit.
    initial begin
        int cyc, dceN, owrN;
        logic [7:0] rop;
        for (int i = 0; i < RAM_DEPTH; i++) initVal[i] = 8'($urandom);
        initVal[0] = 8'hFE;
        for (int i = 0; i < RAM_DEPTH; i++) modelMem[i] = initVal[i];
        modelDp = '0; modelDirty = 0; modelOp = '0; modelCnt = '0; modelA = '0;

        reset            = 1'b1;
        ifc.operation_in = OP_IN;
        ifc.count_in     = 4'd1;
        ifc.op_valid     = 1'b1;
        ifc.cd           = 8'h55;
        ifc.crda         = 1'b1;
        ifc.ordy         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_strobes", {27'd0, ifc.op_ack, ifc.dce, ifc.cack, ifc.owr, ifc.dp_ce}, 32'd0);
        checkOutput("reset_operation", {24'd0, ifc.operation}, 32'd0);
        checkOutput("reset_count", {28'd0, ifc.count}, 32'd0);
        checkOutput("reset_a", {24'd0, ifc.a}, 32'd0);
        checkOutput("reset_dp_cache", {20'd0, ifc.dp_cache}, 32'd0);
        reset        = 1'b0;
        ifc.op_valid = 1'b0;

        applyStimulus(OP_INC, 4'd3, 8'h00, 0, 0, cyc, dceN, owrN);
        checkOutput("inc_fetch_latency", cyc, 2);
        checkOutput("inc_fetch_dce", dceN, 2);
        checkOutput("inc_fetch_a", {24'd0, ifc.a}, 32'h01);

        applyStimulus(OP_INC, 4'd0, 8'h00, 0, 0, cyc, dceN, owrN);
        applyStimulus(OP_DEC, 4'd2, 8'h00, 0, 0, cyc, dceN, owrN);
        checkOutput("fwd_dce", dceN, 0);
        checkOutput("fwd_a", {24'd0, ifc.a}, 32'h0F);

        applyStimulus(OP_DECDP, 4'd0, 8'h00, 0, 0, cyc, dceN, owrN);
        checkOutput("decdp_latency", cyc, 1);
        checkOutput("decdp_dp", {20'd0, ifc.dp}, 32'hFF0);

        applyStimulus(OP_IN, 4'd1, 8'h7F, 2, 0, cyc, dceN, owrN);
        checkOutput("in_latency", cyc, 3);
        checkOutput("in_a", {24'd0, ifc.a}, 32'h7F);

        applyStimulus(OP_INCDP, 4'd1, 8'h00, 0, 0, cyc, dceN, owrN);
        applyStimulus(OP_IN, 4'd1, 8'h41, 0, 0, cyc, dceN, owrN);
        applyStimulus(OP_INCDP, 4'd1, 8'h00, 0, 0, cyc, dceN, owrN);
        applyStimulus(OP_DECDP, 4'd1, 8'h00, 0, 0, cyc, dceN, owrN);
        applyStimulus(OP_OUT, 4'd1, 8'h00, 0, 3, cyc, dceN, owrN);
        checkOutput("out_owr_cycles", owrN, 4);
        checkOutput("out_latency", cyc, 5);
        checkOutput("out_a", {24'd0, ifc.a}, 32'h41);

        repeat (200) begin
            rop = 8'h01 << $urandom_range(0, 7);
            applyStimulus(rop, 4'($urandom_range(0, 15)), 8'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3), cyc, dceN, owrN);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end

        @(negedge clk);
        ifc.operation_in = OP_OUT;
        ifc.count_in     = 4'd1;
        ifc.op_valid     = 1'b1;
        ifc.ordy         = 1'b0;
        ifc.crda         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("emit_owr", {31'd0, ifc.owr}, 32'd1);
        checkOutput("emit_od", {24'd0, ifc.od}, {24'd0, modelMem[modelDp]});
        reset = 1'b1;
        #1;
        checkOutput("emit_reset_strobes", {27'd0, ifc.op_ack, ifc.dce, ifc.cack, ifc.owr, ifc.dp_ce}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("emit_reset_operation", {24'd0, ifc.operation}, 32'd0);
        checkOutput("emit_reset_a", {24'd0, ifc.a}, 32'd0);
        checkOutput("emit_reset_dp_cache", {20'd0, ifc.dp_cache}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_owr", {31'd0, ifc.owr}, 32'd0);
        checkOutput("post_reset_idle_issue", {31'd0, ifc.dce}, 32'd1);
        ifc.op_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
